// File: rtl/mem_port_arb.sv
// Shared memory-port arbiter: LS has fixed priority over IF, with a starvation
// guard that forces an IF grant after STARVE_MAX consecutive LS grants.
module mem_port_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_wen,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_wen,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy,
    output logic                grant_ls
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                if_resp_valid_q, if_resp_valid_d;
    logic                ls_resp_valid_q, ls_resp_valid_d;
    logic [DATA_W-1:0]   if_resp_data_q, if_resp_data_d;
    logic [DATA_W-1:0]   ls_resp_data_q, ls_resp_data_d;

    logic idle_s;
    logic starve_s;
    logic gnt_ls_s;
    logic gnt_if_s;

    // Grant decision; readies are suppressed while reset is held
    always_comb begin
        idle_s   = (state_q == IDLE) && !reset;
        starve_s = if_req_valid && (cnt_q == CNT_MAX);
        gnt_ls_s = idle_s && ls_req_valid && !starve_s;
        gnt_if_s = idle_s && if_req_valid && !gnt_ls_s;
    end

    // Next-state, latch and response-routing logic
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        if_resp_valid_d = 1'b0;
        ls_resp_valid_d = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        ls_resp_data_d  = ls_resp_data_q;
        case (state_q)
            IDLE: begin
                if (gnt_ls_s) begin
                    state_d = REQ;
                    owner_d = 1'b1;
                    addr_d  = ls_req_addr;
                    wen_d   = ls_req_wen;
                    wdata_d = ls_req_wdata;
                    wmask_d = ls_req_wmask;
                    // Count LS wins only while IF is actually waiting
                    if (if_req_valid && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (gnt_if_s) begin
                    state_d = REQ;
                    owner_d = 1'b0;
                    addr_d  = if_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = {DATA_W{1'b0}};
                    wmask_d = {MASK_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        ls_resp_valid_d = 1'b1;
                        ls_resp_data_d  = mem_resp_data;
                    end else begin
                        if_resp_valid_d = 1'b1;
                        if_resp_data_d  = mem_resp_data;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= {CNT_W{1'b0}};
            owner_q         <= 1'b0;
            addr_q          <= {ADDR_W{1'b0}};
            wen_q           <= 1'b0;
            wdata_q         <= {DATA_W{1'b0}};
            wmask_q         <= {MASK_W{1'b0}};
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            if_resp_data_q  <= {DATA_W{1'b0}};
            ls_resp_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            if_resp_valid_q <= if_resp_valid_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            ls_resp_data_q  <= ls_resp_data_d;
        end
    end

    assign if_req_ready  = gnt_if_s;
    assign ls_req_ready  = gnt_ls_s;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_resp_data  = ls_resp_data_q;
    assign busy          = (state_q != IDLE);
    assign grant_ls      = owner_q;

endmodule
